// File: rtl/seq_loop_sequencer.sv
// Control FSM for one HLS-style sequential loop: PRE, BODY_STAGES body states per
// iteration, POST, DONE. Exports state and iteration/quit/finish strobes for monitoring.
module seq_loop_sequencer #(
   parameter int CNT_WIDTH   = 16,
   parameter int BODY_STAGES = 3,
   parameter int FSM_WIDTH   = 3,
   localparam int STAGE_W    = (BODY_STAGES > 1) ? $clog2(BODY_STAGES) : 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ap_start,
   input  logic [CNT_WIDTH-1:0] trip_count,
   input  logic                 abort,
   input  logic                 body_ack,
   output logic                 ap_ready,
   output logic                 ap_idle,
   output logic                 ap_done,
   output logic                 body_en,
   output logic [STAGE_W-1:0]   body_stage,
   output logic [CNT_WIDTH-1:0] iter_idx,
   output logic [FSM_WIDTH-1:0] cur_state,
   output logic                 iter_start,
   output logic                 iter_end,
   output logic                 loop_quit,
   output logic                 finish,
   output logic                 one_state_loop
);

   typedef enum logic [FSM_WIDTH-1:0] {
      S_IDLE = FSM_WIDTH'(0),
      S_PRE  = FSM_WIDTH'(1),
      S_ITER = FSM_WIDTH'(2),
      S_POST = FSM_WIDTH'(3),
      S_DONE = FSM_WIDTH'(4)
   } state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] trip_q;
   logic [CNT_WIDTH-1:0] trip_m1;
   logic                 last_stage;
   logic                 last_iter;

   // trip_m1 is only consulted in ITER, which is unreachable with trip_q==0,
   // so the wrap of 0-1 never matters and iter_idx can never overrun.
   assign trip_m1    = trip_q - CNT_WIDTH'(1);
   assign last_stage = (body_stage == STAGE_W'(BODY_STAGES - 1));
   assign last_iter  = (iter_idx == trip_m1);

   // The only input-to-output paths: abort and body_ack steer these two strobes.
   assign iter_end  = (state == S_ITER) && !abort && body_ack && last_stage;
   assign loop_quit = ((state == S_PRE)  && (abort || (trip_q == '0))) ||
                      ((state == S_ITER) && (abort || (iter_end && last_iter)));

   assign finish         = ap_done;
   assign cur_state      = state;
   assign one_state_loop = (BODY_STAGES == 1);

   // NOTE: every register here uses <= so all state updates see the pre-edge
   // values; blocking assignments would make results depend on statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         trip_q     <= '0;
         iter_idx   <= '0;
         body_stage <= '0;
         ap_ready   <= 1'b0;
         ap_idle    <= 1'b1;
         ap_done    <= 1'b0;
         body_en    <= 1'b0;
         iter_start <= 1'b0;
      end else begin
         ap_ready   <= 1'b0;
         ap_done    <= 1'b0;
         iter_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ap_start) begin
                  trip_q   <= trip_count;
                  ap_ready <= 1'b1;
                  ap_idle  <= 1'b0;
                  state    <= S_PRE;
               end
            end
            S_PRE: begin
               if (abort || (trip_q == '0)) begin
                  state <= S_POST;
               end else begin
                  iter_idx   <= '0;
                  body_stage <= '0;
                  body_en    <= 1'b1;
                  iter_start <= 1'b1;
                  state      <= S_ITER;
               end
            end
            S_ITER: begin
               // abort outranks body_ack: no stage or iteration advance on exit.
               if (abort) begin
                  body_en <= 1'b0;
                  state   <= S_POST;
               end else if (body_ack) begin
                  if (!last_stage) begin
                     body_stage <= body_stage + STAGE_W'(1);
                  end else if (last_iter) begin
                     body_en <= 1'b0;
                     state   <= S_POST;
                  end else begin
                     iter_idx   <= iter_idx + CNT_WIDTH'(1);
                     body_stage <= '0;
                     iter_start <= 1'b1;
                  end
               end
            end
            S_POST: begin
               ap_done <= 1'b1;
               state   <= S_DONE;
            end
            S_DONE: begin
               // ap_start is deliberately not sampled here; IDLE always follows.
               ap_idle <= 1'b1;
               state   <= S_IDLE;
            end
            default: begin
               body_en <= 1'b0;
               ap_idle <= 1'b1;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_loop_sequencer.sv
// Bench for seq_loop_sequencer: directed runs with expected strobe events queued per
// instance (3-stage and 1-stage bodies) and checked by a cycle-stamped monitor.
module tb_seq_loop_sequencer;

   typedef enum int {EV_READY, EV_ISTART, EV_IEND, EV_QUIT, EV_DONE} ev_kind_t;
   typedef struct {
      int       cyc;
      ev_kind_t kind;
      int       idx;
   } ev_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   // 3-stage instance
   logic        start3 = 1'b0, abort3 = 1'b0, ack3 = 1'b1;
   logic [15:0] trip3 = '0;
   logic        ready3, idle3, done3, en3, istart3, iend3, quit3, fin3, osl3;
   logic [1:0]  stage3;
   logic [15:0] idx3;
   logic [2:0]  state3;

   // 1-stage instance
   logic        start1 = 1'b0, abort1 = 1'b0, ack1 = 1'b1;
   logic [15:0] trip1 = '0;
   logic        ready1, idle1, done1, en1, istart1, iend1, quit1, fin1, osl1;
   logic [0:0]  stage1;
   logic [15:0] idx1;
   logic [2:0]  state1;

   int  cyc     = 0;
   int  n_tests = 0;
   int  n_fail  = 0;
   int  en_cnt3 = 0;
   bit  mon_on  = 1'b0;
   ev_t exp_q[2][$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   seq_loop_sequencer #(.CNT_WIDTH(16), .BODY_STAGES(3), .FSM_WIDTH(3)) dut3 (
      .clock(clock), .reset(reset), .ap_start(start3), .trip_count(trip3),
      .abort(abort3), .body_ack(ack3), .ap_ready(ready3), .ap_idle(idle3),
      .ap_done(done3), .body_en(en3), .body_stage(stage3), .iter_idx(idx3),
      .cur_state(state3), .iter_start(istart3), .iter_end(iend3),
      .loop_quit(quit3), .finish(fin3), .one_state_loop(osl3)
   );

   seq_loop_sequencer #(.CNT_WIDTH(16), .BODY_STAGES(1), .FSM_WIDTH(3)) dut1 (
      .clock(clock), .reset(reset), .ap_start(start1), .trip_count(trip1),
      .abort(abort1), .body_ack(ack1), .ap_ready(ready1), .ap_idle(idle1),
      .ap_done(done1), .body_en(en1), .body_stage(stage1), .iter_idx(idx1),
      .cur_state(state1), .iter_start(istart1), .iter_end(iend1),
      .loop_quit(quit1), .finish(fin1), .one_state_loop(osl1)
   );

   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic push(input int inst, input int c, input ev_kind_t k, input int idx);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      e.idx  = idx;
      exp_q[inst].push_back(e);
   endtask

   // Monitor side: every strobe seen is matched against the oldest expected event.
   task automatic observe(input int inst, input ev_kind_t k, input int idx);
      ev_t e;
      n_tests++;
      if (exp_q[inst].size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event dut%0d: got %s idx %0d at cycle %0d, expected none",
                  inst, k.name(), idx, cyc);
         return;
      end
      e = exp_q[inst].pop_front();
      if (e.kind != k || e.cyc != cyc || (e.idx >= 0 && e.idx != idx)) begin
         n_fail++;
         $display("FAIL event dut%0d: got %s idx %0d at cycle %0d, expected %s idx %0d at cycle %0d",
                  inst, k.name(), idx, cyc, e.kind.name(), e.idx, e.cyc);
      end
   endtask

   always @(negedge clock) begin
      if (mon_on) begin
         if (en3) en_cnt3++;
         if (ready3)  observe(0, EV_READY,  int'(idx3));
         if (istart3) observe(0, EV_ISTART, int'(idx3));
         if (iend3)   observe(0, EV_IEND,   int'(idx3));
         if (quit3)   observe(0, EV_QUIT,   int'(idx3));
         if (done3)   observe(0, EV_DONE,   int'(idx3));
         if (fin3 != done3) check("finish_eq_done3", int'(fin3), int'(done3));
         if (ready1)  observe(1, EV_READY,  int'(idx1));
         if (istart1) observe(1, EV_ISTART, int'(idx1));
         if (iend1)   observe(1, EV_IEND,   int'(idx1));
         if (quit1)   observe(1, EV_QUIT,   int'(idx1));
         if (done1)   observe(1, EV_DONE,   int'(idx1));
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected run to end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int en_before;

      // Reset state
      tick(2);
      sample();
      check("rst_idle3",   int'(idle3),  1);
      check("rst_state3",  int'(state3), 0);
      check("rst_ready3",  int'(ready3), 0);
      check("rst_done3",   int'(done3),  0);
      check("rst_en3",     int'(en3),    0);
      check("rst_idx3",    int'(idx3),   0);
      check("rst_stage3",  int'(stage3), 0);
      check("rst_quit3",   int'(quit3),  0);
      check("rst_osl3",    int'(osl3),   0);
      check("rst_osl1",    int'(osl1),   1);
      check("rst_idle1",   int'(idle1),  1);
      tick();
      reset  = 1'b0;
      mon_on = 1'b1;
      tick();

      // T1: trip=3, body_ack always 1
      en_before = en_cnt3;
      k = cyc;
      start3 = 1'b1; trip3 = 16'd3; ack3 = 1'b1;
      push(0, k + 1, EV_READY, -1);
      for (int i = 0; i < 3; i++) begin
         push(0, k + 2 + 3 * i, EV_ISTART, i);
         push(0, k + 4 + 3 * i, EV_IEND,   i);
      end
      push(0, k + 10, EV_QUIT, 2);
      push(0, k + 12, EV_DONE, -1);
      tick();
      start3 = 1'b0;
      tick(12);
      sample();
      check("t1_idle_after", int'(idle3), 1);
      check("t1_en_cycles",  en_cnt3 - en_before, 9);

      // T2: trip=0 skips the body
      en_before = en_cnt3;
      k = cyc + 1;
      tick();
      start3 = 1'b1; trip3 = 16'd0;
      push(0, k + 1, EV_READY, -1);
      push(0, k + 1, EV_QUIT,  -1);
      push(0, k + 3, EV_DONE,  -1);
      tick();
      start3 = 1'b0;
      tick(3);
      sample();
      check("t2_idle_after", int'(idle3), 1);
      check("t2_en_cycles",  en_cnt3 - en_before, 0);

      // T3: trip=2, stall 4 cycles at iteration 0 stage 1
      en_before = en_cnt3;
      k = cyc + 1;
      tick();
      start3 = 1'b1; trip3 = 16'd2;
      push(0, k + 1,  EV_READY,  -1);
      push(0, k + 2,  EV_ISTART, 0);
      push(0, k + 8,  EV_IEND,   0);
      push(0, k + 9,  EV_ISTART, 1);
      push(0, k + 11, EV_IEND,   1);
      push(0, k + 11, EV_QUIT,   1);
      push(0, k + 13, EV_DONE,   -1);
      tick();
      start3 = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         ack3 = 1'b0;
         sample();
         check("t3_stall_stage", int'(stage3), 1);
         check("t3_stall_iend",  int'(iend3),  0);
      end
      tick();
      ack3 = 1'b1;
      tick(7);
      sample();
      check("t3_idle_after", int'(idle3), 1);
      check("t3_en_cycles",  en_cnt3 - en_before, 10);

      // T4: trip=5, abort at iteration 1 stage 2 with body_ack=1
      k = cyc + 1;
      tick();
      start3 = 1'b1; trip3 = 16'd5;
      push(0, k + 1, EV_READY,  -1);
      push(0, k + 2, EV_ISTART, 0);
      push(0, k + 4, EV_IEND,   0);
      push(0, k + 5, EV_ISTART, 1);
      push(0, k + 7, EV_QUIT,   1);
      push(0, k + 9, EV_DONE,   -1);
      tick();
      start3 = 1'b0;
      tick(6);
      abort3 = 1'b1;
      sample();
      check("t4_abort_stage", int'(stage3), 2);
      check("t4_abort_idx",   int'(idx3),   1);
      check("t4_abort_iend",  int'(iend3),  0);
      check("t4_abort_quit",  int'(quit3),  1);
      tick();
      abort3 = 1'b0;
      sample();
      check("t4_post_state", int'(state3), 3);
      tick(2);
      sample();
      check("t4_idle_after", int'(idle3), 1);

      // T5: reset during iteration 2 of trip=4, then a clean rerun
      k = cyc + 1;
      tick();
      start3 = 1'b1; trip3 = 16'd4;
      push(0, k + 1, EV_READY,  -1);
      push(0, k + 2, EV_ISTART, 0);
      push(0, k + 4, EV_IEND,   0);
      push(0, k + 5, EV_ISTART, 1);
      push(0, k + 7, EV_IEND,   1);
      push(0, k + 8, EV_ISTART, 2);
      tick();
      start3 = 1'b0;
      tick(8);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sample();
      check("t5_rst_idle",  int'(idle3),  1);
      check("t5_rst_state", int'(state3), 0);
      check("t5_rst_en",    int'(en3),    0);
      check("t5_rst_done",  int'(done3),  0);
      check("t5_rst_idx",   int'(idx3),   0);
      tick();
      k = cyc;
      start3 = 1'b1; trip3 = 16'd2;
      push(0, k + 1, EV_READY,  -1);
      push(0, k + 2, EV_ISTART, 0);
      push(0, k + 4, EV_IEND,   0);
      push(0, k + 5, EV_ISTART, 1);
      push(0, k + 7, EV_IEND,   1);
      push(0, k + 7, EV_QUIT,   1);
      push(0, k + 9, EV_DONE,   -1);
      tick();
      start3 = 1'b0;
      tick();
      sample();
      check("t5_rerun_idx",   int'(idx3),   0);
      check("t5_rerun_stage", int'(stage3), 0);
      check("t5_rerun_en",    int'(en3),    1);
      tick(8);
      sample();
      check("t5_idle_after", int'(idle3), 1);

      // abort while idle is ignored
      tick();
      abort3 = 1'b1;
      sample();
      check("idle_abort_quit", int'(quit3), 0);
      tick();
      abort3 = 1'b0;
      sample();
      check("idle_abort_state", int'(state3), 0);

      // T6: single-stage body, trip=1, ap_start held -> back-to-back runs
      tick();
      k = cyc;
      start1 = 1'b1; trip1 = 16'd1; ack1 = 1'b1;
      for (int r = 0; r < 2; r++) begin
         push(1, k + 1 + 5 * r, EV_READY,  -1);
         push(1, k + 2 + 5 * r, EV_ISTART, 0);
         push(1, k + 2 + 5 * r, EV_IEND,   0);
         push(1, k + 2 + 5 * r, EV_QUIT,   0);
         push(1, k + 4 + 5 * r, EV_DONE,   -1);
      end
      tick(2);
      sample();
      check("t6_stage_zero", int'(stage1), 0);
      check("t6_en",         int'(en1),    1);
      tick(3);
      sample();
      check("t6_gap_idle",  int'(idle1),  1);
      check("t6_gap_state", int'(state1), 0);
      tick();
      start1 = 1'b0;
      tick(4);
      sample();
      check("t6_idle_after", int'(idle1), 1);
      tick(2);

      // Any expected event never observed is a failure
      check("q_empty_dut3", exp_q[0].size(), 0);
      check("q_empty_dut1", exp_q[1].size(), 0);
      for (int q = 0; q < 2; q++)
         foreach (exp_q[q][i])
            $display("FAIL missing_event dut%0d: got nothing, expected %s idx %0d at cycle %0d",
                     q, exp_q[q][i].kind.name(), exp_q[q][i].idx, exp_q[q][i].cyc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
